gpu_framebuffer_dp: RTL and testbench
=====================================

GPU_FRAMEBUFFER_DP -- requirements
Module: gpu_framebuffer_dp

Interface
REQ-001 The block SHALL have the parameter WORD_WIDTH, default 64, giving the storage word width in bits (a multiple of 8).
REQ-002 The block SHALL have the parameter DEPTH, default 1200, giving the number of words.
REQ-003 The block SHALL have the parameter ADDR_WIDTH, default 11, giving the address width (2^ADDR_WIDTH >= DEPTH).
REQ-004 The block SHALL have the port clock, input, 1 bit: single clock; all state updates on its falling edge.
REQ-005 The block SHALL have the port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have the port address, input, ADDR_WIDTH bits: CPU port word address.
REQ-007 The block SHALL have the port in, input, WORD_WIDTH bits: CPU write data.
REQ-008 The block SHALL have the port write, input, 1 bit: CPU write strobe.
REQ-009 The block SHALL have the port byte_enable, input, WORD_WIDTH/8 bits: per-byte write mask; bit i gates in[8i+7:8i].
REQ-010 The block SHALL have the port out, output, WORD_WIDTH bits: CPU read data.
REQ-011 The block SHALL have the port scan_address, input, ADDR_WIDTH bits: display-port read address.
REQ-012 The block SHALL have the port scan_out, output, WORD_WIDTH bits: display-port read data.
REQ-013 The block SHALL have the port clear_start, input, 1 bit: request a fill of the whole buffer.
REQ-014 The block SHALL have the port clear_value, input, WORD_WIDTH bits: fill word, sampled when clear_start is accepted.
REQ-015 The block SHALL have the port busy, output, 1 bit: high while the clear engine owns the write port.
REQ-016 The block SHALL have the port clear_done, output, 1 bit: single-cycle pulse when a clear completes.
REQ-017 The block SHALL have the port write_dropped, output, 1 bit: single-cycle pulse when a CPU write is discarded.

Function
REQ-018 The CPU port SHALL return mem[address] on out one falling edge after the address is presented (latency 1), every cycle.
REQ-019 The scan port SHALL return mem[scan_address] on scan_out with latency 1, independently of the CPU port, every cycle including while busy.
REQ-020 A CPU write with write=1 and busy=0 SHALL update only the bytes whose byte_enable bit is 1; the other bytes of the word SHALL be preserved.
REQ-021 A same-cycle read and write of one address, on either port, SHALL return the pre-write data (read-before-write).
REQ-022 A read with address >= DEPTH SHALL return all zeros, and a write with address >= DEPTH SHALL leave memory unchanged and pulse write_dropped.
REQ-023 The clear FSM SHALL have the states IDLE, CLEAR and DONE.
REQ-024 In IDLE, clear_start=1 SHALL latch clear_value, zero the clear pointer and move the FSM to CLEAR.
REQ-025 In CLEAR, the FSM SHALL write the latched value to all bytes at the pointer and increment the pointer each cycle; after the write to DEPTH-1 it SHALL go to DONE (exactly DEPTH write cycles).
REQ-026 In DONE, clear_done=1 for one cycle and the FSM SHALL return to IDLE.
REQ-027 busy SHALL be 1 in CLEAR and DONE and 0 in IDLE.
REQ-028 clear_start SHALL be ignored while busy=1.
REQ-029 A CPU write while busy=1 SHALL be discarded and pulse write_dropped in that cycle.
REQ-030 A CPU write in the same cycle that clear_start is accepted SHALL be performed; the clear then overwrites it.

Reset
REQ-031 While reset_n=0 on a falling edge, the FSM SHALL go to IDLE and the pointer SHALL clear.
REQ-032 While reset_n=0 on a falling edge, out, scan_out, busy, clear_done and write_dropped SHALL become 0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset during CLEAR SHALL abort the clear and leave memory partially filled, with no clear_done pulse.
REQ-035 CPU writes SHALL be ignored while reset_n=0.

Structure
REQ-036 The FSM state encoding and the default WORD_WIDTH, DEPTH and ADDR_WIDTH constants SHALL live in the shared package gpu_pkg.
REQ-037 The storage SHALL be the single sub-module gpu_fb_ram: one byte-enabled write port and two registered read ports, inferable as block RAM.
REQ-038 The clear FSM and the write-port mux SHALL reside in gpu_framebuffer_dp.

Verification
REQ-039 The bench SHALL cover: write 0x1122334455667788 to address 5 with byte_enable=0xFF, then read 5 -> out=0x1122334455667788 one cycle later.
REQ-040 The bench SHALL cover: with address 5 holding 0x1122334455667788, write 0xAAAAAAAAAAAAAAAA with byte_enable=0x0F -> readback 0x11223344AAAAAAAA.
REQ-041 The bench SHALL cover: scan_address=5 while the CPU writes address 5 in the same cycle -> scan_out shows the old word, and the new word in the next read.
REQ-042 The bench SHALL cover: clear_start with clear_value=0x20 -> busy for exactly 1201 cycles (1200 CLEAR + DONE), clear_done pulses once, addresses 0, 599 and 1199 read 0x20, and a CPU write mid-clear pulses write_dropped and is not stored.
REQ-043 The bench SHALL cover: reset_n=0 at pointer 300 mid-clear -> busy=0 on the next edge, no clear_done, address 299 reads clear_value and address 301 keeps its old data.
REQ-044 The bench SHALL cover: a write to address 1200 -> write_dropped pulse and no memory change, and a read of 1200 -> 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the framebuffer: clear-engine state encoding and
// the default storage geometry (1200 words of 64 bits).
package gpu_pkg;

  localparam int DEF_WORD_WIDTH = 64;
  localparam int DEF_DEPTH      = 1200;
  localparam int DEF_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_e;

endpackage

// File: rtl/gpu_fb_ram.sv
// Framebuffer storage: one byte-enabled write port and two registered read
// ports, all on the falling clock edge, read-before-write on collisions.
module gpu_fb_ram
  import gpu_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [WORD_WIDTH-1:0]   wdata,
  input  logic [WORD_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   raddr_a,
  output logic [WORD_WIDTH-1:0]   rdata_a,
  input  logic [ADDR_WIDTH-1:0]   raddr_b,
  output logic [WORD_WIDTH-1:0]   rdata_b
);

  localparam int NB = WORD_WIDTH / 8;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] rdata_a_d, rdata_a_q;
  logic [WORD_WIDTH-1:0] rdata_b_d, rdata_b_q;

  // Addresses beyond the populated words read as zero.
  always_comb begin
    rdata_a_d = '0;
    rdata_b_d = '0;
    if (32'(raddr_a) < DEPTH) rdata_a_d = mem[raddr_a];
    if (32'(raddr_b) < DEPTH) rdata_b_d = mem[raddr_b];
  end

  always_ff @(negedge clock) begin
    if (we && (32'(waddr) < DEPTH)) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/gpu_framebuffer_dp.sv
// Dual-port framebuffer: CPU read/write port, display scan read port and a
// clear engine that takes over the write port to fill every word.
module gpu_framebuffer_dp
  import gpu_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [WORD_WIDTH-1:0]   in,
  input  logic                    write,
  input  logic [WORD_WIDTH/8-1:0] byte_enable,
  output logic [WORD_WIDTH-1:0]   out,
  input  logic [ADDR_WIDTH-1:0]   scan_address,
  output logic [WORD_WIDTH-1:0]   scan_out,
  input  logic                    clear_start,
  input  logic [WORD_WIDTH-1:0]   clear_value,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    write_dropped
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  clear_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0]   ptr_d, ptr_q;
  logic [WORD_WIDTH-1:0]   fill_d, fill_q;
  logic                    dropped_d, dropped_q;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [WORD_WIDTH-1:0]   ram_wdata;
  logic [WORD_WIDTH/8-1:0] ram_wbe;
  logic                    addr_ok;

  assign addr_ok = (32'(address) < DEPTH);

  // A CPU write accepted alongside clear_start still lands; the fill then
  // overwrites it. Any write while the engine is active is discarded.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    dropped_d = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = address;
    ram_wdata = in;
    ram_wbe   = byte_enable;

    case (state_q)
      IDLE: begin
        if (write) begin
          if (addr_ok) ram_we = 1'b1;
          else         dropped_d = 1'b1;
        end
        if (clear_start) begin
          fill_d  = clear_value;
          ptr_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = fill_q;
        ram_wbe   = '1;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        dropped_d = write;
        if (ptr_q == LAST_PTR) state_d = DONE;
      end
      DONE: begin
        dropped_d = write;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!reset_n) ram_we = 1'b0;
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      fill_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      dropped_q <= dropped_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign clear_done    = (state_q == DONE);
  assign write_dropped = dropped_q;

  gpu_fb_ram #(
    .WORD_WIDTH(WORD_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .wbe    (ram_wbe),
    .raddr_a(address),
    .rdata_a(out),
    .raddr_b(scan_address),
    .rdata_b(scan_out)
  );

endmodule

// File: tb/tb_gpu_framebuffer_dp.sv
// Bench for gpu_framebuffer_dp: directed and random traffic checked against
// an array model of the framebuffer contents.
module tb_gpu_framebuffer_dp;

  localparam int WW    = 64;
  localparam int DEPTH = 1200;
  localparam int AW    = 11;
  localparam int NB    = WW / 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [WW-1:0] in_data;
  logic          write;
  logic [NB-1:0] byte_enable;
  logic [WW-1:0] out_data;
  logic [AW-1:0] scan_address;
  logic [WW-1:0] scan_out;
  logic          clear_start;
  logic [WW-1:0] clear_value;
  logic          busy;
  logic          clear_done;
  logic          write_dropped;

  int checks = 0;
  int fails  = 0;

  logic [WW-1:0] model_mem [DEPTH];

  gpu_framebuffer_dp #(
    .WORD_WIDTH(WW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .in           (in_data),
    .write        (write),
    .byte_enable  (byte_enable),
    .out          (out_data),
    .scan_address (scan_address),
    .scan_out     (scan_out),
    .clear_start  (clear_start),
    .clear_value  (clear_value),
    .busy         (busy),
    .clear_done   (clear_done),
    .write_dropped(write_dropped)
  );

  always #5 clock = ~clock;

  // The design acts on the falling edge; the bench drives and samples on the rising edge.
  task automatic tick();
    @(posedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [WW-1:0] observed,
                             input logic [WW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int addr, input logic [WW-1:0] data,
                               input logic wr, input logic [NB-1:0] be);
    address     = AW'(addr);
    in_data     = data;
    write       = wr;
    byte_enable = be;
  endtask

  function automatic logic [WW-1:0] modelRead(input int addr);
    if (addr < DEPTH) return model_mem[addr];
    return '0;
  endfunction

  function automatic void modelWrite(input int addr, input logic [WW-1:0] data,
                                     input logic [NB-1:0] be);
    if (addr < DEPTH)
      for (int i = 0; i < NB; i++)
        if (be[i]) model_mem[addr][8*i +: 8] = data[8*i +: 8];
  endfunction

  task automatic readCheck(input string tag, input int addr, input logic [WW-1:0] expected);
    applyStimulus(addr, '0, 1'b0, '0);
    tick();
    checkOutput(tag, out_data, expected);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, dones, a, s;
    logic drop_seen, wr, exp_drop;
    logic [WW-1:0] d, exp_out, exp_scan, v, w, old301;
    logic [NB-1:0] be;

    reset_n = 1'b0; write = 1'b0; clear_start = 1'b0; address = '0;
    scan_address = '0; in_data = '0; clear_value = '0; byte_enable = '0;
    repeat (3) tick();
    checkOutput("reset out", out_data, '0);
    checkOutput("reset scan_out", scan_out, '0);
    checkOutput("reset busy", busy, '0);
    checkOutput("reset clear_done", clear_done, '0);
    checkOutput("reset write_dropped", write_dropped, '0);
    reset_n = 1'b1;

    // Full clear with 0x20, a second clear_start and a CPU write injected mid-fill.
    clear_value = 64'h20; clear_start = 1'b1;
    tick();
    clear_start = 1'b0; clear_value = {$urandom, $urandom};
    n = 0; dones = 0; drop_seen = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      if (clear_done === 1'b1) dones++;
      if (n == 601) drop_seen = write_dropped;
      clear_start = (n == 100);
      if (n == 100) clear_value = 64'h55;
      applyStimulus(10, 64'h0BAD_0BAD_0BAD_0BAD, n == 600, '1);
      tick();
      n++;
    end
    clear_start = 1'b0;
    applyStimulus(0, '0, 1'b0, '0);
    checkOutput("clear busy cycles", 64'(n), 64'd1201);
    checkOutput("clear_done pulses", 64'(dones), 64'd1);
    checkOutput("write_dropped mid-clear", 64'(drop_seen), 64'd1);
    checkOutput("clear_done after idle", clear_done, '0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'h20;
    readCheck("clear addr 0", 0, 64'h20);
    readCheck("clear addr 599", 599, 64'h20);
    readCheck("clear addr 1199", 1199, 64'h20);
    readCheck("dropped write not stored", 10, 64'h20);

    // Full-word write and byte-masked write.
    applyStimulus(5, 64'h1122334455667788, 1'b1, 8'hFF);
    tick();
    checkOutput("full write no drop", write_dropped, '0);
    modelWrite(5, 64'h1122334455667788, 8'hFF);
    readCheck("full write readback", 5, 64'h1122334455667788);
    applyStimulus(5, 64'hAAAAAAAAAAAAAAAA, 1'b1, 8'h0F);
    tick();
    modelWrite(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    readCheck("masked write readback", 5, 64'h11223344AAAAAAAA);

    // Collision: both ports see the old word on the writing edge.
    scan_address = AW'(5);
    applyStimulus(5, 64'hCAFEF00D12345678, 1'b1, 8'hFF);
    tick();
    checkOutput("collision scan old", scan_out, 64'h11223344AAAAAAAA);
    checkOutput("collision cpu old", out_data, 64'h11223344AAAAAAAA);
    applyStimulus(5, '0, 1'b0, '0);
    tick();
    modelWrite(5, 64'hCAFEF00D12345678, 8'hFF);
    checkOutput("collision scan new", scan_out, 64'hCAFEF00D12345678);
    checkOutput("collision cpu new", out_data, 64'hCAFEF00D12345678);

    // Out-of-range write and read.
    applyStimulus(1200, {$urandom, $urandom}, 1'b1, 8'hFF);
    tick();
    checkOutput("oor write dropped", write_dropped, 1'b1);
    applyStimulus(1200, '0, 1'b0, '0);
    scan_address = AW'(1200);
    tick();
    checkOutput("oor cpu read", out_data, '0);
    checkOutput("oor scan read", scan_out, '0);
    checkOutput("oor dropped clears", write_dropped, '0);
    readCheck("oor no alias at 176", 176, modelRead(176));

    // Random traffic, mostly on a small address window so reads hit recent writes.
    for (int k = 0; k < 300; k++) begin
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1200, 2047)) : int'($urandom_range(0, 15));
      s  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1200, 2047)) : int'($urandom_range(0, 15));
      d  = {$urandom, $urandom};
      be = NB'($urandom);
      wr = 1'($urandom_range(0, 1));
      exp_out  = modelRead(a);
      exp_scan = modelRead(s);
      exp_drop = wr && (a >= DEPTH);
      applyStimulus(a, d, wr, be);
      scan_address = AW'(s);
      tick();
      checkOutput("random out", out_data, exp_out);
      checkOutput("random scan_out", scan_out, exp_scan);
      checkOutput("random write_dropped", write_dropped, exp_drop);
      if (wr) modelWrite(a, d, be);
    end

    // Clear accepted together with a CPU write, then aborted by reset at pointer 300.
    old301 = model_mem[301];
    v = {$urandom, $urandom};
    w = {$urandom, $urandom};
    clear_value = v; clear_start = 1'b1;
    applyStimulus(1000, w, 1'b1, 8'hFF);
    tick();
    clear_start = 1'b0;
    applyStimulus(0, '0, 1'b0, '0);
    modelWrite(1000, w, 8'hFF);
    checkOutput("accept write not dropped", write_dropped, '0);
    checkOutput("busy after accept", busy, 1'b1);
    dones = 0;
    repeat (300) begin
      tick();
      if (clear_done === 1'b1) dones++;
    end
    reset_n = 1'b0;
    applyStimulus(301, ~old301, 1'b1, 8'hFF);
    tick();
    checkOutput("abort busy", busy, '0);
    checkOutput("abort clear_done", clear_done, '0);
    checkOutput("abort out", out_data, '0);
    checkOutput("abort write_dropped", write_dropped, '0);
    reset_n = 1'b1;
    applyStimulus(0, '0, 1'b0, '0);
    repeat (3) begin
      tick();
      if (clear_done === 1'b1) dones++;
    end
    checkOutput("abort no done pulse", 64'(dones), 64'd0);
    checkOutput("abort stays idle", busy, '0);
    for (int i = 0; i < 300; i++) model_mem[i] = v;
    readCheck("abort addr 299", 299, v);
    readCheck("abort addr 301", 301, old301);
    readCheck("abort addr 0", 0, modelRead(0));
    readCheck("accept write kept", 1000, w);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
